// File: rtl/uart_rx_os16.sv
// uart_rx_os16: standalone UART receiver, 16x oversampled, 2-of-3 majority
// vote per bit, false-start rejection, hold register with valid/ack handshake.
// Optional feature macro: UART_RX_PARITY_EN (8 data + parity + stop when
// defined, 8N1 otherwise).
module uart_rx_os16 #(
  parameter int P_CLK_FREQ   = 50000000,
  parameter int P_BAUD       = 115200,
  parameter int P_PARITY_ODD = 0
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_rs232_rxd,
  input  logic       I_rd_ack,
  output logic [7:0] O_para_data,
  output logic       O_rx_valid,
  output logic       O_rx_done,
  output logic       O_frame_err,
  output logic       O_parity_err,
  output logic       O_overrun,
  output logic       O_busy
);

  localparam int DIV = P_CLK_FREQ / (P_BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic          rxd_s1, rxd_s2, rxd_d, fall;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    os_cnt, os_nxt;
  logic [1:0]    smp;
  logic          bit_val, decide;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          shift_en, stop_dec;
  logic          par_bad, good, load, ovr_set, ferr_c;
`ifdef UART_RX_PARITY_EN
  logic          par_dec, perr_c;
`endif

  // Two-flop synchronizer plus a delayed copy for falling-edge detection;
  // all held at the idle level in reset so no false edge on release.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_d  <= 1'b1;
    end else begin
      rxd_s1 <= I_rs232_rxd;
      rxd_s2 <= rxd_s1;
      rxd_d  <= rxd_s2;
    end
  end

  assign fall   = rxd_d & ~rxd_s2;
  assign tick   = (state_q != S_IDLE) && (div_cnt == DIV_LAST);
  assign os_nxt = os_cnt + 4'd1;
  assign decide = tick && (os_nxt == 4'd9);
  // Third sample is the live synchronized line at the deciding tick.
  assign bit_val = (smp[0] & smp[1]) | (smp[0] & rxd_s2) | (smp[1] & rxd_s2);
  assign O_busy  = (state_q != S_IDLE);

  // Baud divider: parked at zero in IDLE, so it starts phase-aligned to the
  // detected start edge.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)                        div_cnt <= '0;
    else if (state_q == S_IDLE || tick) div_cnt <= '0;
    else                                 div_cnt <= div_cnt + DW'(1);
  end

  // Oversample phase, majority samples, bit index and data shifter.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      os_cnt  <= '0;
      smp     <= 2'b11;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state_q == S_IDLE) begin
      os_cnt  <= '0;
      bit_idx <= '0;
    end else begin
      if (tick) os_cnt <= os_nxt;
      if (tick && os_nxt == 4'd7) smp[0] <= rxd_s2;
      if (tick && os_nxt == 4'd8) smp[1] <= rxd_s2;
      if (shift_en) begin
        shreg   <= {bit_val, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state and per-decision strobes; STOP leaves at its mid-bit
  // decision so the next start edge can be caught right away.
  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    stop_dec = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_dec  = 1'b0;
`endif
    case (state_q)
      S_IDLE:  if (fall) state_d = S_START;
      S_START: if (decide) state_d = bit_val ? S_IDLE : S_DATA;
      S_DATA: begin
        if (decide) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state_d = S_PARITY;
`else
          if (bit_idx == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (decide) begin
          par_dec = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (decide) begin
          stop_dec = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stop-decision outcome: frame error beats parity error beats delivery.
  assign ferr_c  = stop_dec & ~bit_val;
  assign good    = stop_dec & bit_val & ~par_bad;
  assign load    = good & (~O_rx_valid | I_rd_ack);
  assign ovr_set = good & ~load;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (P_PARITY_ODD != 0);
  assign perr_c = stop_dec & bit_val & par_bad;

  // Parity verdict latched at the parity decision, consumed at stop.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)               par_bad <= 1'b0;
    else if (state_q == S_IDLE) par_bad <= 1'b0;
    else if (par_dec)           par_bad <= (^shreg) ^ bit_val ^ PAR_ODD;
  end

  // Parity error pulse.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) O_parity_err <= 1'b0;
    else          O_parity_err <= perr_c;
  end
`else
  logic unused_par_cfg;
  assign unused_par_cfg = (P_PARITY_ODD != 0);
  assign par_bad        = 1'b0;
  assign O_parity_err   = 1'b0;
`endif

  // Hold register, handshake levels and result pulses.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_para_data <= 8'h00;
      O_rx_valid  <= 1'b0;
      O_rx_done   <= 1'b0;
      O_frame_err <= 1'b0;
      O_overrun   <= 1'b0;
    end else begin
      O_rx_done   <= load;
      O_frame_err <= ferr_c;
      if (load) O_para_data <= shreg;
      if (load)          O_rx_valid <= 1'b1;
      else if (I_rd_ack) O_rx_valid <= 1'b0;
      if (I_rd_ack)     O_overrun <= 1'b0;
      else if (ovr_set) O_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: directed table + hand sequences + randomized frames
// checked against a frame-level handshake model.
module tb_uart_rx_os16;

  localparam int  CLK_FREQ = 50000000;
  localparam int  BAUD     = 115200;
  localparam int  DIV      = CLK_FREQ / (BAUD * 16);
  localparam int  BIT_CLKS = DIV * 16;
  localparam bit  P_ODD    = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int  NB = 11;
`else
  localparam int  NB = 10;
`endif
  // Stop decision tick after the edge.
  localparam int  T_STOP  = (NB - 1) * 16 + 9;
  localparam int  LAT_LO  = T_STOP * DIV;
  localparam int  LAT_HI  = T_STOP * DIV + 4;
  // Clock in which the stop vote happens: 2 synchronizer flops + edge
  // register, then the last clock of tick T_STOP.
  localparam int  DEC_CLK = T_STOP * DIV + 2;
  localparam int  GAP     = 64;
  localparam int  ACK_NONE = 0, ACK_PRE = 1, ACK_DEC = 2;

  logic       clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, rd_ack = 1'b0;
  logic [7:0] para_data;
  logic       rx_valid, rx_done, frame_err, parity_err, overrun, busy;

  uart_rx_os16 #(.P_CLK_FREQ(CLK_FREQ), .P_BAUD(BAUD), .P_PARITY_ODD(0)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_rs232_rxd(rxd), .I_rd_ack(rd_ack),
    .O_para_data(para_data), .O_rx_valid(rx_valid), .O_rx_done(rx_done),
    .O_frame_err(frame_err), .O_parity_err(parity_err), .O_overrun(overrun),
    .O_busy(busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tot_done = 0, tot_ferr = 0, tot_perr = 0, n_wide = 0, last_done_cyc = 0;
  logic p_done = 1'b0, p_ferr = 1'b0, p_perr = 1'b0;
  always @(negedge clk) begin
    if (rx_done)    begin tot_done++; last_done_cyc = cyc; end
    if (frame_err)  tot_ferr++;
    if (parity_err) tot_perr++;
    if ((rx_done && p_done) || (frame_err && p_ferr) || (parity_err && p_perr)) n_wide++;
    p_done = rx_done; p_ferr = frame_err; p_perr = parity_err;
  end

  initial begin
    #(100000 * 20);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  int checks = 0, errors = 0;
  int b_done, b_ferr, b_perr, fall_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_lat(input string name);
    int lat;
    lat = last_done_cyc - fall_cyc;
    checks++;
    if (lat < LAT_LO || lat > LAT_HI) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, lat, LAT_LO, LAT_HI);
    end
  endtask

  task automatic snap();
    b_done = tot_done; b_ferr = tot_ferr; b_perr = tot_perr;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    @(posedge clk); #1;
    rd_ack = 1'b0;
  endtask

  // One frame, clock by clock; ack_at (clocks after the fall) pulses
  // I_rd_ack for that single clock, -1 for none.
  task automatic send(input logic [7:0] d, input bit stop, input bit pb, input int ack_at);
    logic [11:0] bits;
    logic        par;
    par = (^d) ^ P_ODD ^ pb;
`ifdef UART_RX_PARITY_EN
    bits = {1'b1, stop, par, d, 1'b0};
`else
    bits = {1'b1, par, stop, d, 1'b0};
`endif
    snap();
    fall_cyc = cyc;
    for (int c = 0; c < NB * BIT_CLKS + GAP; c++) begin
      rxd    = (c < NB * BIT_CLKS) ? bits[c / BIT_CLKS] : 1'b1;
      rd_ack = (c == ack_at);
      @(posedge clk); #1;
    end
    rd_ack = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    bit         stop;
    int         ack;
    int         e_done;
    int         e_ferr;
    bit         e_valid;
    logic [7:0] e_data;
    bit         e_ovr;
  } vec_t;

  vec_t tbl[6];
  bit   mv, mo;
  logic [7:0] md;

  initial begin
    tbl[0] = '{8'hA5, 1'b1, ACK_NONE, 1, 0, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, ACK_NONE, 0, 1, 1'b1, 8'hA5, 1'b0};
    tbl[2] = '{8'h11, 1'b1, ACK_PRE,  1, 0, 1'b1, 8'h11, 1'b0};
    tbl[3] = '{8'h22, 1'b1, ACK_NONE, 0, 0, 1'b1, 8'h11, 1'b1};
    tbl[4] = '{8'h11, 1'b1, ACK_PRE,  1, 0, 1'b1, 8'h11, 1'b0};
    tbl[5] = '{8'h55, 1'b1, ACK_DEC,  1, 0, 1'b1, 8'h55, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data",   para_data, 8'h00);
    chk("rst_valid",  rx_valid, 0);
    chk("rst_done",   rx_done, 0);
    chk("rst_ferr",   frame_err, 0);
    chk("rst_perr",   parity_err, 0);
    chk("rst_ovr",    overrun, 0);
    chk("rst_busy",   busy, 0);
    rst_n = 1'b1;
    idle(20);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].ack == ACK_PRE) begin
        pulse_ack();
        chk($sformatf("row%0d_ack_valid", i), rx_valid, 0);
        chk($sformatf("row%0d_ack_ovr", i), overrun, 0);
      end
      send(tbl[i].d, tbl[i].stop, 1'b0, (tbl[i].ack == ACK_DEC) ? DEC_CLK : -1);
      chk($sformatf("row%0d_done", i), tot_done - b_done, tbl[i].e_done);
      chk($sformatf("row%0d_ferr", i), tot_ferr - b_ferr, tbl[i].e_ferr);
      chk($sformatf("row%0d_perr", i), tot_perr - b_perr, 0);
      chk($sformatf("row%0d_valid", i), rx_valid, tbl[i].e_valid);
      chk($sformatf("row%0d_data", i), para_data, tbl[i].e_data);
      chk($sformatf("row%0d_ovr", i), overrun, tbl[i].e_ovr);
      if (tbl[i].e_done != 0) chk_lat($sformatf("row%0d_latency", i));
    end

    // Reset in the middle of a frame while a byte is held.
    snap();
    rxd = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("midrst_data",  para_data, 8'h00);
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_busy",  busy, 0);
    rxd = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2 * BIT_CLKS);
    chk("midrst_busy_after", busy, 0);
    chk("midrst_no_done", tot_done - b_done, 0);
    mv = 1'b0; mo = 1'b0; md = 8'h00;

    // 0.3-bit glitch: rejected at the start decision.
    snap();
    rxd = 1'b0;
    repeat (BIT_CLKS * 3 / 10) @(posedge clk);
    #1;
    chk("glitch_busy_during", busy, 1);
    idle(2 * BIT_CLKS);
    chk("glitch_busy_after", busy, 0);
    chk("glitch_no_done", tot_done - b_done, 0);
    chk("glitch_no_ferr", tot_ferr - b_ferr, 0);
    chk("glitch_no_perr", tot_perr - b_perr, 0);

    // Break: line held low for two frame times, one frame error only.
    snap();
    rxd = 1'b0;
    repeat (2 * NB * BIT_CLKS) @(posedge clk);
    #1;
    idle(2 * BIT_CLKS);
    chk("break_ferr_once", tot_ferr - b_ferr, 1);
    chk("break_no_done", tot_done - b_done, 0);
    chk("break_busy_after", busy, 0);

    // Re-arm after break.
    send(8'h96, 1'b1, 1'b0, -1);
    chk("rearm_done", tot_done - b_done, 1);
    chk("rearm_data", para_data, 8'h96);
    chk_lat("rearm_latency");
    mv = 1'b1; md = 8'h96;

`ifdef UART_RX_PARITY_EN
    pulse_ack();
    send(8'h07, 1'b1, 1'b1, -1);
    chk("par_bad_perr", tot_perr - b_perr, 1);
    chk("par_bad_done", tot_done - b_done, 0);
    chk("par_bad_valid", rx_valid, 0);
    send(8'h07, 1'b1, 1'b0, -1);
    chk("par_ok_done", tot_done - b_done, 1);
    chk("par_ok_data", para_data, 8'h07);
    md = 8'h07;
`endif

    // Randomized frames against the handshake model.
    for (int k = 0; k < 5; k++) begin
      logic [7:0] d;
      bit stop, pb, good, ack_d, e_done;
      int am;
      d     = 8'($urandom);
      stop  = ($urandom_range(0, 4) != 0);
      am    = $urandom_range(0, 2);
`ifdef UART_RX_PARITY_EN
      pb    = ($urandom_range(0, 3) == 0);
`else
      pb    = 1'b0;
`endif
      if (am == ACK_PRE) begin
        pulse_ack();
        mv = 1'b0; mo = 1'b0;
      end
      send(d, stop, pb, (am == ACK_DEC) ? DEC_CLK : -1);
      good   = stop && !pb;
      ack_d  = (am == ACK_DEC);
      e_done = good && (!mv || ack_d);
      if (e_done) begin
        md = d; mv = 1'b1; mo = 1'b0;
      end else begin
        if (good) mo = 1'b1;
        if (ack_d && mv) begin mv = 1'b0; mo = 1'b0; end
      end
      chk($sformatf("rnd%0d_done", k), tot_done - b_done, {31'd0, e_done});
      chk($sformatf("rnd%0d_ferr", k), tot_ferr - b_ferr, {31'd0, !stop});
      chk($sformatf("rnd%0d_perr", k), tot_perr - b_perr, {31'd0, stop && pb});
      chk($sformatf("rnd%0d_valid", k), rx_valid, mv);
      chk($sformatf("rnd%0d_data", k), para_data, md);
      chk($sformatf("rnd%0d_ovr", k), overrun, mo);
    end

    chk("pulse_width", n_wide, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

Standalone UART receiver with its own 16x oversampling baud generator. It recovers 8-bit frames from an asynchronous RS-232 line using majority-vote sampling and rejects false starts. It presents each byte through a hold register with a valid/acknowledge handshake. It is the receive end of the design's UART link, fed from the PC side or looped back from the transmit line, and replaces the enable-gated receive path for host-facing ports.

## Interface
- P_CLK_FREQ, 50000000, system clock frequency in Hz
- P_BAUD, 115200, line baud rate
- P_PARITY_ODD, 0, parity sense when parity is compiled in (0 even, 1 odd); ignored otherwise
- I_clk  input  1  system clock
- I_rst_n  input  1  reset, asynchronous, active-low
- I_rs232_rxd  input  1  asynchronous serial line, idle high
- I_rd_ack  input  1  consumer acknowledge; clears O_rx_valid and O_overrun
- O_para_data  output  8  last accepted byte, LSB = first data bit received
- O_rx_valid  output  1  hold register holds an unacknowledged byte
- O_rx_done  output  1  one-cycle pulse when a byte is accepted into the hold register
- O_frame_err  output  1  one-cycle pulse: stop bit sampled low
- O_parity_err  output  1  one-cycle pulse: parity mismatch
- O_overrun  output  1  sticky: a good byte arrived while O_rx_valid=1
- O_busy  output  1  high while the FSM is outside IDLE

## Operation
- Input path: 2-flop synchronizer, both flops reset to 1. A falling edge is detected from the synchronized value and a registered copy of it.
- Tick generator: DIV = P_CLK_FREQ/(P_BAUD*16), integer truncation. A 1-cycle tick fires every DIV clocks. The counter is cleared on the detected start edge so sampling is phase-aligned to it. The counter runs only outside IDLE.
- Bit counter os_cnt 0..15 advances per tick. Samples are taken at os_cnt 7, 8 and 9. The bit value is the 2-of-3 majority, decided at os_cnt 9. A bit ends at 15→0.
- FSM states and transitions:
  - IDLE: on falling edge, go to START.
  - START: if the start decision is 1 (glitch), go to IDLE with no outputs. If it is 0, go to DATA.
  - DATA: shift in 8 bits, LSB first. After bit 7, go to STOP, or to PARITY when parity is compiled in.
  - PARITY: check parity, then go to STOP.
  - STOP: go to IDLE at the stop decision (os_cnt 9), not at the end of the bit, to allow resync on the next edge.
- At the stop decision, exactly one of the following happens:
  - Stop bit = 0: O_frame_err pulses. The byte is discarded and the hold register is unchanged.
  - Stop bit = 1 with parity error: O_parity_err pulses. The byte is discarded.
  - Otherwise, with O_rx_valid=0 or I_rd_ack=1 in the same cycle: O_para_data loads, O_rx_valid=1, O_rx_done pulses.
  - Otherwise, with O_rx_valid=1 and no I_rd_ack: the byte is discarded, O_overrun is set, and O_rx_done does not pulse.
- I_rd_ack with O_rx_valid=0 has no effect.
- Line held low (break): frame error is reported once. IDLE re-arms only on a new falling edge, which requires the line to return high first.
- Reset mid-frame: the FSM goes to IDLE, counters clear, all outputs return to reset values, and any partial byte is lost.

## Timing
- Reset values: O_para_data=8'h00. O_rx_valid, O_rx_done, O_frame_err, O_parity_err, O_overrun and O_busy are all 0.
- Decision for bit index N (start=0) falls at tick 16N+9 after the edge.
- Stop decision: 8N1 is N=9, giving 153 ticks. With parity it is N=10, giving 169 ticks.
- Latency at defaults (DIV=27), 8N1: O_rx_done asserts between 4131 and 4135 clocks after the line's falling edge. This covers synchronizer, edge-detect and tick-phase slack.
- All pulse outputs last exactly 1 cycle. O_rx_valid and O_overrun are registered levels.
- I_rd_ack takes effect on the next clock edge.

## Configuration
- UART_RX_PARITY_EN defined: the frame is 8 data bits, 1 parity bit and 1 stop bit.
  - Parity is even when P_PARITY_ODD=0 and odd when it is 1.
  - The PARITY state is present and O_parity_err is driven.
- UART_RX_PARITY_EN undefined: the frame is 8N1.
  - The PARITY state is omitted and O_parity_err is tied to 0.

## Test plan
- Send 8'hA5 as 8N1 at 115200 into an idle line: O_rx_done pulses once within clocks 4131–4135 after the edge, O_para_data=8'hA5, O_rx_valid=1, no error flags.
- Send a 0.3-bit low glitch on the idle line: FSM returns to IDLE after the start decision, with no O_rx_done, no error pulses, and O_busy low afterwards.
- Send 8'h3C with the stop bit forced low: O_frame_err pulses 1 cycle, O_para_data is unchanged, O_rx_valid is unchanged.
- Send 8'h11 without ack, then 8'h22: O_para_data stays 8'h11 and O_overrun=1. Assert I_rd_ack: O_rx_valid=0 and O_overrun=0 next cycle.
- Assert I_rd_ack in the same cycle as the stop decision of 8'h55 while 8'h11 is held: O_para_data=8'h55, O_rx_valid=1, O_overrun=0.
- With UART_RX_PARITY_EN and P_PARITY_ODD=0, send 8'h07 with parity bit 0: O_parity_err pulses and the byte is discarded. Resend with parity bit 1: O_rx_done pulses and O_para_data=8'h07.
